config_loader: RTL and testbench

- Upstream feeder for the logic-tile configuration chain. It accepts a configuration bitstream as parallel words over a valid/ready handshake and serializes it into the chain's serial input.
- It drives the chain's shift enable and chain clear, counts exactly CHAIN_LENGTH bits, and holds the fabric's user-logic reset low until configuration completes.
- One instance sits at the head of the daisy-chained tile array, between the external loader interface and the first tile.

---
 rtl/config_loader.sv | 138 +++++++++++++
 tb/tb_config_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// config_loader: head-of-chain feeder for the tile configuration daisy chain.
// Accepts bitstream words over valid/ready, clears the chain, then shifts
// exactly CHAIN_LENGTH bits LSB-first into the chain while holding the fabric
// user-logic reset low. All outputs come straight from flops.
module config_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 1024,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_serial,
  output logic                  config_enable,
  output logic                  config_nreset,
  output logic                  fabric_nreset,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT_C  = CNT_W'(CHAIN_LENGTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX_C  = IDX_W'(WORD_WIDTH - 1);
  localparam logic [CLR_W-1:0] CLR_LOAD_C  = CLR_W'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_WAIT_WORD = 3'd2,
    S_SHIFT     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t                state_r;
  logic [WORD_WIDTH-1:0] shift_r;
  logic [IDX_W-1:0]      idx_r;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic [CLR_W-1:0]      clr_cnt_r;

  // Loader FSM: sequencing, counters and every registered output in one place.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_r       <= S_IDLE;
      shift_r       <= '0;
      idx_r         <= '0;
      bit_cnt_r     <= '0;
      clr_cnt_r     <= '0;
      word_ready    <= 1'b0;
      config_serial <= 1'b0;
      config_enable <= 1'b0;
      config_nreset <= 1'b1;
      fabric_nreset <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          // Only a quiescent loader honours start; DONE stays sticky otherwise.
          if (start) begin
            state_r       <= S_CLEAR;
            clr_cnt_r     <= CLR_LOAD_C;
            bit_cnt_r     <= '0;
            config_nreset <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            fabric_nreset <= 1'b0;
          end else begin
            state_r <= state_r;
          end
        end

        S_CLEAR: begin
          if (clr_cnt_r == '0) begin
            state_r       <= S_WAIT_WORD;
            config_nreset <= 1'b1;
            word_ready    <= 1'b1;
          end else begin
            clr_cnt_r <= clr_cnt_r - CLR_W'(1);
          end
        end

        S_WAIT_WORD: begin
          // The chain is frozen (enable low) for as long as the source stalls.
          if (word_valid && word_ready) begin
            state_r       <= S_SHIFT;
            word_ready    <= 1'b0;
            config_enable <= 1'b1;
            config_serial <= word_in[0];
            shift_r       <= word_in >> 1'b1;
            idx_r         <= '0;
          end else begin
            state_r <= S_WAIT_WORD;
          end
        end

        S_SHIFT: begin
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
          if (bit_cnt_r == LAST_BIT_C) begin
            // Last chain bit just went out; leftover word bits are dropped.
            state_r       <= S_DONE;
            config_enable <= 1'b0;
            config_serial <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            fabric_nreset <= 1'b1;
          end else if (idx_r == LAST_IDX_C) begin
            state_r       <= S_WAIT_WORD;
            config_enable <= 1'b0;
            config_serial <= 1'b0;
            word_ready    <= 1'b1;
          end else begin
            config_serial <= shift_r[0];
            shift_r       <= shift_r >> 1'b1;
            idx_r         <= idx_r + IDX_W'(1);
          end
        end

        default: begin
          state_r       <= S_IDLE;
          word_ready    <= 1'b0;
          config_serial <= 1'b0;
          config_enable <= 1'b0;
          config_nreset <= 1'b1;
          fabric_nreset <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a 20-bit chain fed with 0xA5,0x3C,0x0F
// and a second 8-bit chain instance fed with 0x96.
module tb_config_loader;

  logic clock = 1'b0;
  logic nreset;
  always #5 clock = ~clock;

  // 20-bit chain instance
  logic       start, word_valid, word_ready, config_serial, config_enable;
  logic       config_nreset, fabric_nreset, busy, done;
  logic [7:0] word_in;

  // 8-bit chain instance
  logic       start8, word_valid8, word_ready8, config_serial8, config_enable8;
  logic       config_nreset8, fabric_nreset8, busy8, done8;
  logic [7:0] word_in8;

  int total = 0;
  int bad   = 0;

  config_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(20), .CLEAR_CYCLES(2)) dut (
    .clock(clock), .nreset(nreset), .start(start), .word_in(word_in),
    .word_valid(word_valid), .word_ready(word_ready), .config_serial(config_serial),
    .config_enable(config_enable), .config_nreset(config_nreset),
    .fabric_nreset(fabric_nreset), .busy(busy), .done(done)
  );

  config_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(8), .CLEAR_CYCLES(2)) dut8 (
    .clock(clock), .nreset(nreset), .start(start8), .word_in(word_in8),
    .word_valid(word_valid8), .word_ready(word_ready8), .config_serial(config_serial8),
    .config_enable(config_enable8), .config_nreset(config_nreset8),
    .fabric_nreset(fabric_nreset8), .busy(busy8), .done(done8)
  );

  // Monitors: count enable cycles, handshakes and clear cycles, record serial bits.
  logic        mon_rst, mon_rst8;
  int          en_cnt, hs_cnt, clr_cnt;
  logic [63:0] stream;
  int          en8, hs8, rdy_after8;
  logic [63:0] stream8;

  assign word_in  = (hs_cnt == 0) ? 8'hA5 : (hs_cnt == 1) ? 8'h3C : 8'h0F;
  assign word_in8 = 8'h96;

  // Monitor for the 20-bit instance, sampled on the active edge (pre-edge values).
  always @(posedge clock) begin
    if (mon_rst) begin
      en_cnt <= 0; hs_cnt <= 0; clr_cnt <= 0; stream <= 64'd0;
    end else begin
      if (config_enable) begin
        if (en_cnt < 64) stream[en_cnt] <= config_serial;
        en_cnt <= en_cnt + 1;
      end
      if (word_valid && word_ready) hs_cnt <= hs_cnt + 1;
      if (!config_nreset) clr_cnt <= clr_cnt + 1;
    end
  end

  // Monitor for the 8-bit instance.
  always @(posedge clock) begin
    if (mon_rst8) begin
      en8 <= 0; hs8 <= 0; rdy_after8 <= 0; stream8 <= 64'd0;
    end else begin
      if (config_enable8) begin
        if (en8 < 64) stream8[en8] <= config_serial8;
        en8 <= en8 + 1;
      end
      if (word_valid8 && word_ready8) hs8 <= hs8 + 1;
      if (word_ready8 && hs8 != 0) rdy_after8 <= rdy_after8 + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start one load on the 20-bit instance and run until done (bounded).
  // gap: cycles word_valid is withheld before the second word.
  // pulse_mid: assert start for a couple of cycles mid-SHIFT.
  task automatic do_load(input int gap, input bit pulse_mid, output int cycles, output int gap_bad);
    bit gap_done;
    start = 1'b1; mon_rst = 1'b1;
    tick();
    start = 1'b0; mon_rst = 1'b0;
    cycles = 1; gap_bad = 0; gap_done = (gap == 0);
    while (!done && cycles < 200) begin
      if (!gap_done && hs_cnt == 1 && word_ready) begin
        word_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          tick(); cycles++;
          if (!word_ready || config_enable) gap_bad++;
        end
        word_valid = 1'b1;
        gap_done = 1'b1;
      end else begin
        start = (pulse_mid && en_cnt >= 5 && en_cnt < 7);
        tick(); cycles++;
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    tick(); tick();
    total++;
    if ({word_ready, config_serial, config_enable, config_nreset, fabric_nreset, busy, done} !== 7'b0001000) begin
      bad++;
      $display("FAIL reset_outputs: got %b expected 0001000",
        {word_ready, config_serial, config_enable, config_nreset, fabric_nreset, busy, done});
    end
    total++;
    if ({word_ready8, config_serial8, config_enable8, config_nreset8, fabric_nreset8, busy8, done8} !== 7'b0001000) begin
      bad++;
      $display("FAIL reset_outputs8: got %b expected 0001000",
        {word_ready8, config_serial8, config_enable8, config_nreset8, fabric_nreset8, busy8, done8});
    end
    nreset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc, gb;
    do_load(0, 1'b0, cyc, gb);
    total++; if (cyc !== 26) begin bad++; $display("FAIL basic_done_cycle: got %0d expected 26", cyc); end
    total++; if (clr_cnt !== 2) begin bad++; $display("FAIL basic_clear_cycles: got %0d expected 2", clr_cnt); end
    total++; if (hs_cnt !== 3) begin bad++; $display("FAIL basic_handshakes: got %0d expected 3", hs_cnt); end
    total++; if (en_cnt !== 20) begin bad++; $display("FAIL basic_enable_cycles: got %0d expected 20", en_cnt); end
    total++; if (stream !== 64'h00000000000F3CA5) begin bad++; $display("FAIL basic_stream: got %h expected 00000000000f3ca5", stream); end
    total++;
    if ({done, fabric_nreset, busy, config_enable, word_ready, config_nreset} !== 6'b110001) begin
      bad++;
      $display("FAIL basic_done_outputs: got %b expected 110001",
        {done, fabric_nreset, busy, config_enable, word_ready, config_nreset});
    end
  endtask

  task automatic test_gap();
    int cyc, gb;
    do_load(5, 1'b0, cyc, gb);
    total++; if (cyc !== 31) begin bad++; $display("FAIL gap_done_cycle: got %0d expected 31", cyc); end
    total++; if (gb !== 0) begin bad++; $display("FAIL gap_ready_enable: got %0d bad gap cycles expected 0", gb); end
    total++; if (hs_cnt !== 3) begin bad++; $display("FAIL gap_handshakes: got %0d expected 3", hs_cnt); end
    total++; if (en_cnt !== 20) begin bad++; $display("FAIL gap_enable_cycles: got %0d expected 20", en_cnt); end
    total++; if (stream !== 64'h00000000000F3CA5) begin bad++; $display("FAIL gap_stream: got %h expected 00000000000f3ca5", stream); end
  endtask

  task automatic test_restart();
    int cyc;
    tick(); tick();
    total++;
    if ({done, fabric_nreset, config_enable} !== 3'b110) begin
      bad++; $display("FAIL restart_sticky_done: got %b expected 110", {done, fabric_nreset, config_enable});
    end
    start = 1'b1; mon_rst = 1'b1;
    tick();
    start = 1'b0; mon_rst = 1'b0;
    total++;
    if ({done, fabric_nreset, config_nreset, busy} !== 4'b0001) begin
      bad++; $display("FAIL restart_first_edge: got %b expected 0001", {done, fabric_nreset, config_nreset, busy});
    end
    tick();
    total++; if (config_nreset !== 1'b0) begin bad++; $display("FAIL restart_clear_2nd: got %b expected 0", config_nreset); end
    tick();
    total++;
    if ({config_nreset, word_ready} !== 2'b11) begin
      bad++; $display("FAIL restart_clear_end: got %b expected 11", {config_nreset, word_ready});
    end
    cyc = 3;
    while (!done && cyc < 200) begin tick(); cyc++; end
    total++; if (cyc !== 26) begin bad++; $display("FAIL restart_done_cycle: got %0d expected 26", cyc); end
    total++; if (clr_cnt !== 2) begin bad++; $display("FAIL restart_clear_cycles: got %0d expected 2", clr_cnt); end
    total++; if (en_cnt !== 20) begin bad++; $display("FAIL restart_enable_cycles: got %0d expected 20", en_cnt); end
  endtask

  task automatic test_ignore();
    int cyc, gb;
    do_load(0, 1'b1, cyc, gb);
    total++; if (cyc !== 26) begin bad++; $display("FAIL ignore_done_cycle: got %0d expected 26", cyc); end
    total++; if (hs_cnt !== 3) begin bad++; $display("FAIL ignore_handshakes: got %0d expected 3", hs_cnt); end
    total++; if (en_cnt !== 20) begin bad++; $display("FAIL ignore_enable_cycles: got %0d expected 20", en_cnt); end
    total++; if (stream !== 64'h00000000000F3CA5) begin bad++; $display("FAIL ignore_stream: got %h expected 00000000000f3ca5", stream); end
  endtask

  task automatic test_reset_mid();
    int cyc, gb;
    start = 1'b1; mon_rst = 1'b1;
    tick();
    start = 1'b0; mon_rst = 1'b0;
    cyc = 0;
    while (en_cnt < 10 && cyc < 100) begin tick(); cyc++; end
    total++; if (en_cnt !== 10) begin bad++; $display("FAIL midreset_reach: got %0d enable cycles expected 10", en_cnt); end
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    total++;
    if ({word_ready, config_serial, config_enable, config_nreset, fabric_nreset, busy, done} !== 7'b0001000) begin
      bad++;
      $display("FAIL midreset_outputs: got %b expected 0001000",
        {word_ready, config_serial, config_enable, config_nreset, fabric_nreset, busy, done});
    end
    tick();
    total++;
    if ({busy, done, config_enable} !== 3'b000) begin
      bad++; $display("FAIL midreset_idle: got %b expected 000", {busy, done, config_enable});
    end
    do_load(0, 1'b0, cyc, gb);
    total++; if (cyc !== 26) begin bad++; $display("FAIL midreset_done_cycle: got %0d expected 26", cyc); end
    total++; if (clr_cnt !== 2) begin bad++; $display("FAIL midreset_clear_cycles: got %0d expected 2", clr_cnt); end
    total++; if (en_cnt !== 20) begin bad++; $display("FAIL midreset_enable_cycles: got %0d expected 20", en_cnt); end
    total++; if (stream !== 64'h00000000000F3CA5) begin bad++; $display("FAIL midreset_stream: got %h expected 00000000000f3ca5", stream); end
  endtask

  task automatic test_short();
    int cyc;
    start8 = 1'b1; mon_rst8 = 1'b1;
    tick();
    start8 = 1'b0; mon_rst8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 100) begin tick(); cyc++; end
    total++; if (cyc !== 12) begin bad++; $display("FAIL short_done_cycle: got %0d expected 12", cyc); end
    total++; if (hs8 !== 1) begin bad++; $display("FAIL short_handshakes: got %0d expected 1", hs8); end
    total++; if (en8 !== 8) begin bad++; $display("FAIL short_enable_cycles: got %0d expected 8", en8); end
    total++; if (stream8 !== 64'h0000000000000096) begin bad++; $display("FAIL short_stream: got %h expected 0000000000000096", stream8); end
    total++; if (rdy_after8 !== 0) begin bad++; $display("FAIL short_no_rewait: got %0d ready cycles expected 0", rdy_after8); end
    total++;
    if ({done8, fabric_nreset8, busy8} !== 3'b110) begin
      bad++; $display("FAIL short_done_outputs: got %b expected 110", {done8, fabric_nreset8, busy8});
    end
  endtask

  initial begin
    nreset = 1'b0; start = 1'b0; word_valid = 1'b1; mon_rst = 1'b1;
    start8 = 1'b0; word_valid8 = 1'b1; mon_rst8 = 1'b1;
    tick();
    mon_rst = 1'b0; mon_rst8 = 1'b0;
    test_reset();
    test_basic();
    test_gap();
    test_restart();
    test_ignore();
    test_reset_mid();
    test_short();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
